// File: rtl/xdma_cfg_deframer.sv
// Reassembles multi-beat DMA configuration frames into one wide configuration word.
// Optional COLLECT idle-gap timeout is enabled by defining XDMA_CFG_DEFRAMER_TIMEOUT_EN.
module xdma_cfg_deframer #(
    parameter int unsigned DataWidth     = 512,
    parameter int unsigned AddrWidth     = 48,
    parameter int unsigned IdWidth       = 4,
    parameter int unsigned FrameLenWidth = 4,
    parameter int unsigned MaxFrames     = 4,
    parameter int unsigned TimeoutCycles = 1024,
    localparam int unsigned FirstPayW    = DataWidth - 1 - FrameLenWidth - IdWidth - 2 * AddrWidth,
    localparam int unsigned RestPayW     = DataWidth - 1 - FrameLenWidth,
    localparam int unsigned PayW         = FirstPayW + (MaxFrames - 1) * RestPayW
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [DataWidth-1:0]     in_data_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic                     out_dma_type_o,
    output logic [FrameLenWidth-1:0] out_frame_length_o,
    output logic [IdWidth-1:0]       out_dma_id_o,
    output logic [AddrWidth-1:0]     out_reader_addr_o,
    output logic [AddrWidth-1:0]     out_writer_addr_o,
    output logic [PayW-1:0]          out_payload_o,
    output logic                     error_o
);

    localparam int unsigned IdLsb = 1 + FrameLenWidth;
    localparam int unsigned RaLsb = IdLsb + IdWidth;
    localparam int unsigned WaLsb = RaLsb + AddrWidth;
    localparam logic [FrameLenWidth-1:0] MaxLen = FrameLenWidth'(MaxFrames);
    localparam logic [FrameLenWidth-1:0] OneLen = FrameLenWidth'(1);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        OUT
    } state_t;

    state_t                   state;
    logic [FrameLenWidth-1:0] frame_cnt;

    logic                     in_type;
    logic [FrameLenWidth-1:0] in_len;
    logic [IdWidth-1:0]       in_id;
    logic [AddrWidth-1:0]     in_raddr;
    logic [AddrWidth-1:0]     in_waddr;
    logic [FirstPayW-1:0]     in_pay0;
    logic [RestPayW-1:0]      in_payk;
    logic                     accept;
    logic                     len_ok;
    logic                     hdr_match;

    assign in_type   = in_data_i[0];
    assign in_len    = in_data_i[FrameLenWidth:1];
    assign in_id     = in_data_i[IdLsb +: IdWidth];
    assign in_raddr  = in_data_i[RaLsb +: AddrWidth];
    assign in_waddr  = in_data_i[WaLsb +: AddrWidth];
    assign in_pay0   = in_data_i[DataWidth-1 -: FirstPayW];
    assign in_payk   = in_data_i[DataWidth-1 -: RestPayW];

    assign in_ready_o = (state != OUT);
    assign accept     = in_valid_i && in_ready_o;
    assign len_ok     = (in_len != '0) && (in_len <= MaxLen);
    assign hdr_match  = (in_type == out_dma_type_o) && (in_len == out_frame_length_o);

`ifdef XDMA_CFG_DEFRAMER_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TimeoutCycles + 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TimeoutCycles - 1);
    logic [TmoW-1:0] tmo_cnt;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state              <= IDLE;
            frame_cnt          <= '0;
            out_valid_o        <= 1'b0;
            error_o            <= 1'b0;
            out_dma_type_o     <= 1'b0;
            out_frame_length_o <= '0;
            out_dma_id_o       <= '0;
            out_reader_addr_o  <= '0;
            out_writer_addr_o  <= '0;
            out_payload_o      <= '0;
`ifdef XDMA_CFG_DEFRAMER_TIMEOUT_EN
            tmo_cnt            <= '0;
`endif
        end else begin
            error_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (len_ok) begin
                            // Whole payload is rewritten so slots beyond frame_length read as zero.
                            out_dma_type_o     <= in_type;
                            out_frame_length_o <= in_len;
                            out_dma_id_o       <= in_id;
                            out_reader_addr_o  <= in_raddr;
                            out_writer_addr_o  <= in_waddr;
                            out_payload_o      <= PayW'(in_pay0);
                            frame_cnt          <= OneLen;
`ifdef XDMA_CFG_DEFRAMER_TIMEOUT_EN
                            tmo_cnt            <= '0;
`endif
                            if (in_len == OneLen) begin
                                state       <= OUT;
                                out_valid_o <= 1'b1;
                            end else begin
                                state <= COLLECT;
                            end
                        end else begin
                            error_o <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (accept) begin
`ifdef XDMA_CFG_DEFRAMER_TIMEOUT_EN
                        tmo_cnt <= '0;
`endif
                        if (hdr_match) begin
                            for (int unsigned k = 1; k < MaxFrames; k++) begin
                                if (frame_cnt == FrameLenWidth'(k)) begin
                                    out_payload_o[FirstPayW + (k - 1) * RestPayW +: RestPayW] <= in_payk;
                                end
                            end
                            frame_cnt <= frame_cnt + 1'b1;
                            if ((frame_cnt + 1'b1) == out_frame_length_o) begin
                                state       <= OUT;
                                out_valid_o <= 1'b1;
                            end
                        end else begin
                            state     <= IDLE;
                            frame_cnt <= '0;
                            error_o   <= 1'b1;
                        end
                    end
`ifdef XDMA_CFG_DEFRAMER_TIMEOUT_EN
                    else if (tmo_cnt == TmoLast) begin
                        state     <= IDLE;
                        frame_cnt <= '0;
                        tmo_cnt   <= '0;
                        error_o   <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                OUT: begin
                    if (out_ready_i) begin
                        state       <= IDLE;
                        frame_cnt   <= '0;
                        out_valid_o <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    frame_cnt   <= '0;
                    out_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xdma_cfg_deframer.sv
// Scoreboard bench for xdma_cfg_deframer; adapts the timeout test to XDMA_CFG_DEFRAMER_TIMEOUT_EN.
module tb_xdma_cfg_deframer;

    localparam int DW  = 512;
    localparam int AW  = 48;
    localparam int IW  = 4;
    localparam int FLW = 4;
    localparam int MF  = 4;
    localparam int F0P = DW - 1 - FLW - IW - 2 * AW;
    localparam int RP  = DW - 1 - FLW;
    localparam int PW  = F0P + (MF - 1) * RP;

    typedef struct packed {
        logic            typ;
        logic [FLW-1:0]  len;
        logic [IW-1:0]   id;
        logic [AW-1:0]   ra;
        logic [AW-1:0]   wa;
        logic [MF-1:0][511:0] slot;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [DW-1:0]  in_data;
    logic           out_valid;
    logic           out_ready;
    logic           out_type;
    logic [FLW-1:0] out_len;
    logic [IW-1:0]  out_id;
    logic [AW-1:0]  out_ra;
    logic [AW-1:0]  out_wa;
    logic [PW-1:0]  out_pay;
    logic           err;

    int n_checks = 0;
    int n_errors = 0;
    int err_seen = 0;
    int exp_err  = 0;
    int n_out    = 0;
    logic prev_valid = 1'b0;
    exp_t sb[$];

    always #5 clk = ~clk;

    xdma_cfg_deframer #(
        .DataWidth    (DW),
        .AddrWidth    (AW),
        .IdWidth      (IW),
        .FrameLenWidth(FLW),
        .MaxFrames    (MF),
        .TimeoutCycles(16)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .in_valid_i        (in_valid),
        .in_ready_o        (in_ready),
        .in_data_i         (in_data),
        .out_valid_o       (out_valid),
        .out_ready_i       (out_ready),
        .out_dma_type_o    (out_type),
        .out_frame_length_o(out_len),
        .out_dma_id_o      (out_id),
        .out_reader_addr_o (out_ra),
        .out_writer_addr_o (out_wa),
        .out_payload_o     (out_pay),
        .error_o           (err)
    );

    task automatic check(input string tag, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [DW-1:0] build_f0(input logic typ, input logic [FLW-1:0] len,
            input logic [IW-1:0] id, input logic [AW-1:0] ra, input logic [AW-1:0] wa,
            input logic [F0P-1:0] p);
        return {p, wa, ra, id, len, typ};
    endfunction

    function automatic logic [DW-1:0] build_fk(input logic typ, input logic [FLW-1:0] len,
            input logic [RP-1:0] p);
        return {p, len, typ};
    endfunction

    // Called one time unit after a rising edge; returns one unit after the accepting edge.
    task automatic send_beat(input logic [DW-1:0] d);
        int guard = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) check("send_ready_timeout", 512'(in_ready), 512'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int guard = 0;
        while (sb.size() != 0 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check("drain", 512'(sb.size()), 512'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            exp_t e;
            if (err) err_seen++;
            if (out_valid && !prev_valid) check("err_on_valid_rise", 512'(err), 512'(0));
            if (out_valid && out_ready) begin
                n_out++;
                check("sb_has_entry", 512'(sb.size() > 0), 512'(1));
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("out_type", 512'(out_type), 512'(e.typ));
                    check("out_len",  512'(out_len),  512'(e.len));
                    check("out_id",   512'(out_id),   512'(e.id));
                    check("out_raddr", 512'(out_ra),  512'(e.ra));
                    check("out_waddr", 512'(out_wa),  512'(e.wa));
                    check("slot0", 512'(out_pay[F0P-1:0]), e.slot[0]);
                    for (int k = 1; k < MF; k++)
                        check($sformatf("slot%0d", k), 512'(out_pay[F0P + (k-1)*RP +: RP]), e.slot[k]);
                end
            end
        end
        prev_valid = out_valid;
    end

    initial begin
        exp_t e;
        logic [F0P-1:0] p0;
        logic [RP-1:0]  p1, p2;
        logic [PW-1:0]  snap_pay;
        logic [AW-1:0]  snap_ra;
        int first;

        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 512'(out_valid), 512'(0));
        check("rst_err",   512'(err),       512'(0));
        check("rst_ready", 512'(in_ready),  512'(1));
        check("rst_pay",   512'(out_pay != '0), 512'(0));
        check("rst_id",    512'(out_id),    512'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single frame
        p0 = F0P'(rnd512());
        e = '0;
        e.typ = 1'b1; e.len = 4'd1; e.id = 4'd5; e.ra = 48'h1000; e.wa = 48'h2000;
        e.slot[0] = 512'(p0);
        sb.push_back(e);
        send_beat(build_f0(1'b1, 4'd1, 4'd5, 48'h1000, 48'h2000, p0));
        check("t40_latency", 512'(out_valid), 512'(1));
        wait_drain();

        // Three frames with stalled consumer
        out_ready = 1'b0;
        p0 = F0P'(rnd512());
        p1 = RP'(rnd512());
        p2 = RP'(rnd512());
        e = '0;
        e.typ = 1'b0; e.len = 4'd3; e.id = 4'd9; e.ra = 48'hABCD_0000_1234; e.wa = 48'h0000_5555_AAAA;
        e.slot[0] = 512'(p0); e.slot[1] = 512'(p1); e.slot[2] = 512'(p2);
        sb.push_back(e);
        send_beat(build_f0(1'b0, 4'd3, 4'd9, 48'hABCD_0000_1234, 48'h0000_5555_AAAA, p0));
        send_beat(build_fk(1'b0, 4'd3, p1));
        send_beat(build_fk(1'b0, 4'd3, p2));
        snap_pay = out_pay;
        snap_ra  = out_ra;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t41_ready_low",  512'(in_ready), 512'(0));
            check("t41_valid_held", 512'(out_valid), 512'(1));
            check("t41_pay_stable", 512'(out_pay == snap_pay), 512'(1));
            check("t41_ra_stable",  512'(out_ra), 512'(snap_ra));
        end
        check("t41_no_early_out", 512'(n_out), 512'(1));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_drain();

        // Illegal lengths in IDLE
        send_beat(build_f0(1'b1, 4'd0, 4'd1, 48'h1, 48'h2, '0));
        send_beat(build_f0(1'b1, 4'd5, 4'd1, 48'h1, 48'h2, '0));
        exp_err += 2;
        settle(3);
        check("t42_err_count", 512'(err_seen), 512'(exp_err));
        check("t42_no_out",    512'(n_out), 512'(2));
        check("t42_idle",      512'(in_ready), 512'(1));
        @(posedge clk);
        #1;

        // Type mismatch on second frame, then a good single frame
        send_beat(build_f0(1'b0, 4'd2, 4'd3, 48'h11, 48'h22, F0P'(rnd512())));
        send_beat(build_fk(1'b1, 4'd2, RP'(rnd512())));
        exp_err += 1;
        settle(2);
        check("t43_err_count", 512'(err_seen), 512'(exp_err));
        check("t43_no_out",    512'(n_out), 512'(2));
        @(posedge clk);
        #1;
        p0 = F0P'(rnd512());
        e = '0;
        e.typ = 1'b0; e.len = 4'd1; e.id = 4'd7; e.ra = 48'h3333; e.wa = 48'h4444;
        e.slot[0] = 512'(p0);
        sb.push_back(e);
        send_beat(build_f0(1'b0, 4'd1, 4'd7, 48'h3333, 48'h4444, p0));
        wait_drain();

        // Reset mid-COLLECT
        send_beat(build_f0(1'b1, 4'd3, 4'd2, 48'hBEEF, 48'hCAFE, F0P'(rnd512())));
        send_beat(build_fk(1'b1, 4'd3, RP'(rnd512())));
        #2;
        rst = 1'b1;
        #1;
        check("t44_valid", 512'(out_valid), 512'(0));
        check("t44_err",   512'(err), 512'(0));
        check("t44_ra",    512'(out_ra), 512'(0));
        check("t44_len",   512'(out_len), 512'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t44_ready_after", 512'(in_ready), 512'(1));
        check("t44_no_err",      512'(err_seen), 512'(exp_err));
        @(posedge clk);
        #1;
        p0 = F0P'(rnd512());
        e = '0;
        e.typ = 1'b1; e.len = 4'd1; e.id = 4'd12; e.ra = 48'h7777; e.wa = 48'h8888;
        e.slot[0] = 512'(p0);
        sb.push_back(e);
        send_beat(build_f0(1'b1, 4'd1, 4'd12, 48'h7777, 48'h8888, p0));
        wait_drain();

        // Idle gap in COLLECT
        p0 = F0P'(rnd512());
        send_beat(build_f0(1'b0, 4'd2, 4'd6, 48'h9999, 48'hAAAA, p0));
`ifdef XDMA_CFG_DEFRAMER_TIMEOUT_EN
        first = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (err && first == 0) first = n;
        end
        exp_err += 1;
        check("t45_tmo_cycle", 512'(first), 512'(17));
        check("t45_idle", 512'(in_ready), 512'(1));
        check("t45_err_count", 512'(err_seen), 512'(exp_err));
        @(posedge clk);
        #1;
`else
        first = 0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (err && first == 0) first = n;
        end
        check("t45_no_tmo", 512'(first), 512'(0));
        check("t45_still_collect", 512'(in_ready), 512'(1));
        @(posedge clk);
        #1;
        p1 = RP'(rnd512());
        e = '0;
        e.typ = 1'b0; e.len = 4'd2; e.id = 4'd6; e.ra = 48'h9999; e.wa = 48'hAAAA;
        e.slot[0] = 512'(p0); e.slot[1] = 512'(p1);
        sb.push_back(e);
        send_beat(build_fk(1'b0, 4'd2, p1));
        wait_drain();
`endif

        settle(2);
        check("final_err_count", 512'(err_seen), 512'(exp_err));
        check("final_sb_empty",  512'(sb.size()), 512'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
